elm_argmax_ctrl: RTL and testbench

ELM_ARGMAX_CTRL -- requirements
Module: elm_argmax_ctrl

---
 rtl/elm_argmax_ctrl.sv | 129 ++++++++++++
 tb/tb_elm_argmax_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/elm_argmax_ctrl.sv
// Argmax controller for an ELM output layer: buffers N_CLASS signed scores per frame,
// scans them sequentially for the largest (lowest index wins ties) and holds the result.
module elm_argmax_ctrl #(
  parameter int unsigned N_CLASS = 10,
  parameter int unsigned W       = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        score_in,
  input  logic                score_valid,
  input  logic                score_last,
  output logic                score_ready,
  output logic [N_CLASS-1:0]  result_onehot,
  output logic [3:0]          result_idx,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic                frame_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StOut} state_e;

  localparam logic [3:0] LastIdx = 4'(N_CLASS - 1);

  state_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [3:0]         cur_q, cur_d;
  logic [3:0]         max_q, max_d;
  logic [3:0]         res_idx_q, res_idx_d;
  logic [N_CLASS-1:0] res_oh_q, res_oh_d;
  logic               frame_err_q, frame_err_d;

  logic signed [W-1:0] buffer_q [N_CLASS];

  logic       xfer;
  logic       cur_wins;
  logic [3:0] win_idx;

  assign score_ready   = (state_q == StLoad);
  assign xfer          = score_valid & score_ready;
  assign result_valid  = (state_q == StOut);
  assign busy          = (state_q != StIdle);
  assign result_idx    = res_idx_q;
  assign result_onehot = res_oh_q;
  assign frame_err     = frame_err_q;

  // Strict greater-than keeps the earlier index on ties.
  assign cur_wins = buffer_q[cur_q] > buffer_q[max_q];
  assign win_idx  = cur_wins ? cur_q : max_q;

  // Score storage needs no reset; every entry is rewritten before a scan reads it.
  always_ff @(posedge clk) begin
    if (xfer) begin
      buffer_q[count_q] <= score_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cur_d       = cur_q;
    max_d       = max_q;
    res_idx_d   = res_idx_q;
    res_oh_d    = res_oh_q;
    frame_err_d = frame_err_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      StLoad: begin
        if (xfer) begin
          count_d = count_q + 4'd1;
          // score_last must coincide exactly with the final score; the frame length is fixed.
          if (score_last != (count_q == LastIdx)) begin
            frame_err_d = 1'b1;
          end
          if (count_q == LastIdx) begin
            state_d = StScan;
            count_d = '0;
            max_d   = '0;
            cur_d   = 4'd1;
          end
        end
      end
      StScan: begin
        max_d = win_idx;
        cur_d = cur_q + 4'd1;
        if (cur_q == LastIdx) begin
          state_d             = StOut;
          res_idx_d           = win_idx;
          res_oh_d            = '0;
          res_oh_d[LastIdx - win_idx] = 1'b1;
        end
      end
      StOut: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      cur_q       <= '0;
      max_q       <= '0;
      res_idx_q   <= '0;
      res_oh_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cur_q       <= cur_d;
      max_q       <= max_d;
      res_idx_q   <= res_idx_d;
      res_oh_q    <= res_oh_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_elm_argmax_ctrl.sv
// Directed bench for elm_argmax_ctrl: expected winners are queued when a frame is driven
// and popped at the result handshake.
module tb_elm_argmax_ctrl;

  localparam int N = 10;
  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] score_in;
  logic         score_valid;
  logic         score_last;
  logic         score_ready;
  logic [N-1:0] result_onehot;
  logic [3:0]   result_idx;
  logic         result_valid;
  logic         result_ready;
  logic         busy;
  logic         frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int frame_sc [N];
  int sb_q [$];
  int last_idx = 0;

  always #5 clk = ~clk;

  elm_argmax_ctrl #(.N_CLASS(N), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .score_in      (score_in),
    .score_valid   (score_valid),
    .score_last    (score_last),
    .score_ready   (score_ready),
    .result_onehot (result_onehot),
    .result_idx    (result_idx),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx();
    int m = 0;
    for (int k = 1; k < N; k++) if (frame_sc[k] > frame_sc[m]) m = k;
    return m;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v = '0;
    v[N-1-idx] = 1'b1;
    return v;
  endfunction

  // Issues start and delivers all N scores; returns at #1 after the final transfer edge.
  task automatic load_scores(input int last_pos, input bit rand_valid, input bit poke_start);
    int  i = 0;
    int  guard = 0;
    logic xf;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (i < N && guard < 500) begin
      score_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      score_in    = W'(frame_sc[i]);
      score_last  = (i == last_pos);
      start       = poke_start;
      @(negedge clk);
      xf = score_valid && score_ready;
      @(posedge clk); #1;
      if (xf) i++;
      guard++;
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
    start       = 1'b0;
    check("load_count", 64'(i), 64'(N));
  endtask

  task automatic run_frame(input int last_pos, input bit rand_valid, input int hold,
                           input bit poke_start);
    int lat = 1;
    int exp_idx;
    sb_q.push_back(model_idx());
    load_scores(last_pos, rand_valid, poke_start);
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(N));
    exp_idx = sb_q[0];
    for (int h = 0; h < hold; h++) begin
      start = poke_start;
      @(negedge clk);
      check("hold_valid", 64'(result_valid), 64'd1);
      check("hold_idx", 64'(result_idx), 64'(exp_idx));
      check("hold_onehot", 64'(result_onehot), 64'(onehot(exp_idx)));
      @(posedge clk); #1;
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    exp_idx = sb_q.pop_front();
    check("out_valid", 64'(result_valid), 64'd1);
    check("out_idx", 64'(result_idx), 64'(exp_idx));
    check("out_onehot", 64'(result_onehot), 64'(onehot(exp_idx)));
    last_idx = exp_idx;
    @(posedge clk); #1 result_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_valid", 64'(result_valid), 64'd0);
      check("post_busy", 64'(busy), 64'd0);
      check("post_idx", 64'(result_idx), 64'(last_idx));
      @(posedge clk); #1;
    end
  endtask

  task automatic set_frame(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    frame_sc[0] = a0; frame_sc[1] = a1; frame_sc[2] = a2; frame_sc[3] = a3;
    frame_sc[4] = a4; frame_sc[5] = a5; frame_sc[6] = a6; frame_sc[7] = a7;
    frame_sc[8] = a8; frame_sc[9] = a9;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; score_in = '0; score_valid = 1'b0; score_last = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(score_ready), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_onehot", 64'(result_onehot), 64'd0);
    check("rst_idx", 64'(result_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);

    // Reference frame, clean framing.
    set_frame(5, -3, 7, 2, 7, -100, 0, 1, 6, 4);
    run_frame(9, 1'b0, 0, 1'b0);
    check("ref_onehot_lit", 64'(result_onehot), 64'(10'b0010000000));
    check("ref_ferr", 64'(frame_err), 64'd0);

    // result_ready while idle is ignored.
    result_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_rdy_valid", 64'(result_valid), 64'd0);
      check("idle_rdy_idx", 64'(result_idx), 64'd2);
      @(posedge clk); #1;
    end
    result_ready = 1'b0;

    set_frame(-9, -8, -1, -7, -12, -20, -30, -40, -45, -50);
    run_frame(9, 1'b0, 0, 1'b0);
    check("neg_idx_lit", 64'(result_idx), 64'd2);

    set_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_frame(9, 1'b0, 0, 1'b0);
    check("zero_onehot_lit", 64'(result_onehot), 64'(10'b1000000000));

    // Random valid gaps, long result backpressure, start poked while busy.
    set_frame(-4, 11, 3, 11, -2, 9, 10, 0, 1, 2);
    run_frame(9, 1'b1, 20, 1'b1);

    // Early score_last: error flagged, frame still runs full length.
    set_frame(1, 2, 3, 4, 50, 6, 7, 8, 9, 10);
    run_frame(3, 1'b0, 0, 1'b0);
    check("early_last_ferr", 64'(frame_err), 64'd1);
    set_frame(3, 1, 4, 1, 5, 9, 2, 6, 5, 35);
    run_frame(9, 1'b1, 2, 1'b0);
    check("sticky_ferr", 64'(frame_err), 64'd1);

    // Reset in the fourth SCAN cycle discards the frame.
    set_frame(8, 7, 6, 5, 4, 3, 2, 1, 0, 99);
    sb_q.push_back(model_idx());
    load_scores(9, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("scan_rst_busy", 64'(busy), 64'd0);
    check("scan_rst_valid", 64'(result_valid), 64'd0);
    check("scan_rst_ready", 64'(score_ready), 64'd0);
    check("scan_rst_ferr", 64'(frame_err), 64'd0);
    check("scan_rst_idx", 64'(result_idx), 64'd0);
    @(posedge clk); #1;

    set_frame(5, -3, 7, 2, 7, -100, 0, 1, 6, 4);
    run_frame(9, 1'b0, 1, 1'b0);
    check("fresh_ferr", 64'(frame_err), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
